// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: issues pops, absorbs the 1-cycle read latency
// and re-presents words as a valid/ready stream through a 3-entry skid buffer.
// Optional m_last burst marker is enabled by defining FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream #(
   parameter int DW        = 8,
   parameter int DEPTH     = 3,
   parameter int BURST_LEN = 4
) (
   input  logic          rd_clk,
   input  logic          rd_rst,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_data,
   output logic          fifo_pop,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
`ifdef FIFO_RD_STREAM_LAST_EN
   output logic          m_last,
`endif
   output logic [1:0]    occupancy
);

   localparam int PW = 2;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] occ_q, occ_d;
   logic          pend_q;
   logic [DW-1:0] buf_q [DEPTH];
   logic          fire;
   logic [2:0]    credit;

   // A pop is only issued when a slot is guaranteed for it even if nothing drains,
   // which keeps m_ready out of the pop path.
   assign credit    = 3'(occ_q) + 3'(pend_q) + 3'd1;
   assign fifo_pop  = ~fifo_empty & ~rd_rst & (credit <= 3'(DEPTH));
   assign m_valid   = (occ_q != '0);
   assign m_data    = buf_q[head_q];
   assign fire      = m_valid & m_ready;
   assign occupancy = occ_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (fire) begin
         head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
      end
      if (pend_q) begin
         tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
      end
      occ_d = occ_q + PW'(pend_q) - PW'(fire);
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         pend_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         pend_q <= fifo_pop;
         if (pend_q) begin
            buf_q[tail_q] <= fifo_data;
         end
      end
   end

   a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
      (pend_q & ~fire) |-> (occ_q < PW'(DEPTH)))
      else $error("skid buffer overflow");

`ifdef FIFO_RD_STREAM_LAST_EN
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   logic [CW-1:0] cnt_q;

   // Beat counter only advances on an accepted beat, so m_last holds through stalls.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         cnt_q <= '0;
      end else if (fire) begin
         cnt_q <= (cnt_q == CW'(BURST_LEN - 1)) ? '0 : cnt_q + CW'(1);
      end
   end

   assign m_last = m_valid & (cnt_q == CW'(BURST_LEN - 1));
`endif

endmodule
